// File: rtl/movi_param.sv
`default_nettype none
// ============================================================================
// Module      : movi_param
// Description : Parametrised immediate-load (MOVI) controller. Latches a
//               destination index, immediate and extension mode on start,
//               arbitrates for the shared data bus, then drives the extended
//               immediate for one cycle while pulsing the selected register
//               write enable. Out-of-range indices complete with err set.
//               Optional feature macro: MOVI_SEXT_EN (honour the sext input;
//               when undefined the immediate is always zero-extended).
// Revision    : 1.0 - initial release
// ============================================================================
module movi_param #(
  parameter int DATA_W   = 16,
  parameter int IMM_W    = 6,
  parameter int NUM_REGS = 4,
  parameter int SEL_W    = 6
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [SEL_W-1:0]    ri,
  input  logic [IMM_W-1:0]    num,
  input  logic                sext,
  input  logic                bus_gnt,
  output logic                bus_req,
  output logic [DATA_W-1:0]   out_to_bus,
  output logic [NUM_REGS-1:0] r_write,
  output logic                done,
  output logic                err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_DRIVE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // One extra bit so NUM_REGS == 2**SEL_W is representable in the compare.
  localparam logic [SEL_W:0] C_NUM_REGS = (SEL_W+1)'(NUM_REGS);

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   ri_q, ri_d;
  logic [IMM_W-1:0]   num_q, num_d;
  logic               err_q, err_d;
  logic               fill_bit;
  logic [DATA_W-1:0]  ext_imm;

`ifdef MOVI_SEXT_EN
  logic               sext_q, sext_d;

  // Extension mode register, loaded alongside the other operands.
  always_ff @(posedge clk) begin
    if (reset) sext_q <= 1'b0;
    else       sext_q <= sext_d;
  end

  // Hold unless a new instruction is accepted in IDLE.
  always_comb begin
    sext_d = sext_q;
    if (state_q == S_IDLE && start) sext_d = sext;
  end

  assign fill_bit = sext_q & num_q[IMM_W-1];
`else
  // The sext port is kept for interface compatibility but has no effect.
  logic unused_sext;
  assign unused_sext = sext;
  assign fill_bit    = 1'b0;
`endif

  generate
    if (IMM_W == DATA_W) begin : g_ext_full
      assign ext_imm = num_q;
    end else begin : g_ext_pad
      assign ext_imm = {{(DATA_W-IMM_W){fill_bit}}, num_q};
    end
  endgenerate

  // State and operand latches; reset drops any partially issued write.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      ri_q    <= '0;
      num_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ri_q    <= ri_d;
      num_q   <= num_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic and operand capture; start is only looked at in IDLE.
  always_comb begin
    state_d = state_q;
    ri_d    = ri_q;
    num_d   = num_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          ri_d  = ri;
          num_d = num;
          if ({1'b0, ri} >= C_NUM_REGS) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (bus_gnt) state_d = S_DRIVE;
      end
      S_DRIVE: begin
        // Grant is not rechecked here: once driving, the write completes.
        state_d = S_DONE;
      end
      S_DONE: begin
        err_d   = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from state and latched operands only.
  always_comb begin
    bus_req = (state_q == S_REQ) || (state_q == S_DRIVE);
    done    = (state_q == S_DONE);
    err     = (state_q == S_DONE) && err_q;
    r_write = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      r_write[i] = (state_q == S_DRIVE) && (ri_q == SEL_W'(i));
    end
  end

  assign out_to_bus = (state_q == S_DRIVE) ? ext_imm : {DATA_W{1'bz}};

endmodule
`default_nettype wire

// File: tb/tb_movi_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_movi_param
// Description : Directed self-checking bench for movi_param (default
//               parameters). Expectation for the sign-extension case follows
//               the MOVI_SEXT_EN macro.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_movi_param;

  localparam int DATA_W   = 16;
  localparam int IMM_W    = 6;
  localparam int NUM_REGS = 4;
  localparam int SEL_W    = 6;

  logic                clk;
  logic                reset;
  logic                start;
  logic [SEL_W-1:0]    ri;
  logic [IMM_W-1:0]    num;
  logic                sext;
  logic                bus_gnt;
  logic                bus_req;
  wire  [DATA_W-1:0]   out_to_bus;
  logic [NUM_REGS-1:0] r_write;
  logic                done;
  logic                err;

  logic [DATA_W-1:0]   bus_z;
  int                  n_checks;
  int                  n_fail;

  movi_param #(
    .DATA_W  (DATA_W),
    .IMM_W   (IMM_W),
    .NUM_REGS(NUM_REGS),
    .SEL_W   (SEL_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .ri        (ri),
    .num       (num),
    .sext      (sext),
    .bus_gnt   (bus_gnt),
    .bus_req   (bus_req),
    .out_to_bus(out_to_bus),
    .r_write   (r_write),
    .done      (done),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; return at the falling edge for sampling/driving.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Full idle-output check.
  task automatic chk_idle(input string tag);
    chk({tag, ".bus_req"}, {31'b0, bus_req}, 32'h0);
    chk({tag, ".r_write"}, {28'b0, r_write}, 32'h0);
    chk({tag, ".done"},    {31'b0, done},    32'h0);
    chk({tag, ".err"},     {31'b0, err},     32'h0);
    chk({tag, ".bus"},     {16'b0, out_to_bus}, {16'b0, bus_z});
  endtask

  logic [DATA_W-1:0] exp_sext_val;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    bus_z    = {DATA_W{1'bz}};
`ifdef MOVI_SEXT_EN
    exp_sext_val = 16'hFFEA;
`else
    exp_sext_val = 16'h002A;
`endif
    reset   = 1'b1;
    start   = 1'b0;
    ri      = '0;
    num     = '0;
    sext    = 1'b0;
    bus_gnt = 1'b0;
    @(negedge clk);
    tick();
    reset = 1'b0;
    chk_idle("reset");

    // Basic: ri=2, num=15, zero-extend, grant tied high.
    start = 1'b1; ri = 6'd2; num = 6'h15; sext = 1'b0; bus_gnt = 1'b1;
    tick();
    start = 1'b0;
    chk("t1.c1.bus_req", {31'b0, bus_req}, 32'h1);
    chk("t1.c1.r_write", {28'b0, r_write}, 32'h0);
    chk("t1.c1.bus",     {16'b0, out_to_bus}, {16'b0, bus_z});
    tick();
    chk("t1.c2.bus",     {16'b0, out_to_bus}, 32'h0015);
    chk("t1.c2.r_write", {28'b0, r_write}, 32'h4);
    chk("t1.c2.bus_req", {31'b0, bus_req}, 32'h1);
    tick();
    chk("t1.c3.done",    {31'b0, done}, 32'h1);
    chk("t1.c3.err",     {31'b0, err},  32'h0);
    chk("t1.c3.bus",     {16'b0, out_to_bus}, {16'b0, bus_z});
    chk("t1.c3.bus_req", {31'b0, bus_req}, 32'h0);
    tick();
    chk_idle("t1.c4");

    // Sign extension case: ri=1, num=2A, sext=1.
    start = 1'b1; ri = 6'd1; num = 6'h2A; sext = 1'b1;
    tick();
    start = 1'b0; sext = 1'b0;
    tick();
    chk("t2.drive.bus",     {16'b0, out_to_bus}, {16'b0, exp_sext_val});
    chk("t2.drive.r_write", {28'b0, r_write}, 32'h2);
    tick();
    chk("t2.done", {31'b0, done}, 32'h1);
    tick();

    // Positive immediate with sext=1 stays unchanged.
    start = 1'b1; ri = 6'd0; num = 6'h15; sext = 1'b1;
    tick();
    start = 1'b0; sext = 1'b0;
    tick();
    chk("t2b.drive.bus", {16'b0, out_to_bus}, 32'h0015);
    tick();
    tick();

    // Grant delayed for 5 cycles after REQ.
    bus_gnt = 1'b0;
    start = 1'b1; ri = 6'd3; num = 6'h3F; sext = 1'b0;
    tick();
    start = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      chk($sformatf("t3.wait%0d.bus_req", i), {31'b0, bus_req}, 32'h1);
      chk($sformatf("t3.wait%0d.r_write", i), {28'b0, r_write}, 32'h0);
      chk($sformatf("t3.wait%0d.bus", i), {16'b0, out_to_bus}, {16'b0, bus_z});
      chk($sformatf("t3.wait%0d.done", i), {31'b0, done}, 32'h0);
      tick();
    end
    bus_gnt = 1'b1;
    chk("t3.c6.bus_req", {31'b0, bus_req}, 32'h1);
    chk("t3.c6.r_write", {28'b0, r_write}, 32'h0);
    tick();
    chk("t3.c7.bus",     {16'b0, out_to_bus}, 32'h003F);
    chk("t3.c7.r_write", {28'b0, r_write}, 32'h8);
    tick();
    chk("t3.c8.done", {31'b0, done}, 32'h1);
    tick();

    // Out-of-range index: error completion in cycle 1, no bus activity.
    start = 1'b1; ri = 6'd7; num = 6'h11;
    tick();
    start = 1'b0;
    chk("t4.done",    {31'b0, done},    32'h1);
    chk("t4.err",     {31'b0, err},     32'h1);
    chk("t4.bus_req", {31'b0, bus_req}, 32'h0);
    chk("t4.r_write", {28'b0, r_write}, 32'h0);
    chk("t4.bus",     {16'b0, out_to_bus}, {16'b0, bus_z});
    tick();
    chk_idle("t4.after");

    // Extra starts while busy; operands changed after issue; grant dropped in DRIVE.
    bus_gnt = 1'b0;
    start = 1'b1; ri = 6'd0; num = 6'h05; sext = 1'b0;
    tick();
    ri = 6'd3; num = 6'h3F; sext = 1'b1;
    tick();
    bus_gnt = 1'b1;
    tick();
    bus_gnt = 1'b0;
    chk("t5.drive.bus",     {16'b0, out_to_bus}, 32'h0005);
    chk("t5.drive.r_write", {28'b0, r_write}, 32'h1);
    tick();
    chk("t5.done", {31'b0, done}, 32'h1);
    chk("t5.err",  {31'b0, err},  32'h0);
    start = 1'b0;
    tick();
    chk_idle("t5.idle1");
    tick();
    chk_idle("t5.idle2");

    // Reset asserted in DRIVE (with start high); following start runs normally.
    bus_gnt = 1'b1;
    start = 1'b1; ri = 6'd2; num = 6'h0A; sext = 1'b0;
    tick();
    start = 1'b0;
    tick();
    chk("t6.drive.r_write", {28'b0, r_write}, 32'h4);
    reset = 1'b1; start = 1'b1;
    tick();
    reset = 1'b0;
    ri = 6'd1; num = 6'h01;
    chk_idle("t6.after_reset");
    tick();
    start = 1'b0;
    chk("t6.req.bus_req", {31'b0, bus_req}, 32'h1);
    tick();
    chk("t6.drive2.bus",     {16'b0, out_to_bus}, 32'h0001);
    chk("t6.drive2.r_write", {28'b0, r_write}, 32'h2);
    tick();
    chk("t6.done2", {31'b0, done}, 32'h1);
    tick();
    chk_idle("t6.end");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/movi_param.md
# movi_param

Parametrised immediate-load (MOVI) controller for the simple CPU datapath. On `start`, it latches a destination register index, an immediate and an extension mode, then requests the shared data bus. Once granted, it drives the zero- or sign-extended immediate onto the bus for one cycle while pulsing the write enable of the selected register. This generalises the fixed 4-register, 16-bit MOVI FSM. It adds configurable register count and widths, bus request/grant arbitration, operand latching, and an error report for out-of-range register indices.

## Interface
Parameters:
- `DATA_W`, 16, bus and register width
- `IMM_W`, 6, immediate field width; must satisfy 1 ≤ IMM_W ≤ DATA_W
- `NUM_REGS`, 4, number of destination registers; must satisfy 1 ≤ NUM_REGS ≤ 2^SEL_W
- `SEL_W`, 6, width of register index field

Ports:
- `clk`  in  1  clock; all state changes on the rising edge
- `reset`  in  1  synchronous, active-high reset
- `start`  in  1  instruction issue strobe; sampled only in IDLE
- `ri`  in  SEL_W  destination register index
- `num`  in  IMM_W  immediate value
- `sext`  in  1  1 = sign-extend `num`, 0 = zero-extend
- `bus_gnt`  in  1  bus grant from arbiter
- `bus_req`  out  1  bus request
- `out_to_bus`  out  DATA_W  tri-state bus drive; high-Z unless in DRIVE
- `r_write`  out  NUM_REGS  one-hot register write enables
- `done`  out  1  one-cycle completion pulse
- `err`  out  1  out-of-range index flag; valid while `done` = 1

## Operation
- States: IDLE, REQ, DRIVE, DONE, held in a registered state variable. All outputs are decoded from the state and the latched operands only; they do not depend on the live `ri`, `num`, `sext` or `start` inputs.
- IDLE:
  - Outputs are `bus_req`=0, `r_write`=0, `done`=0, `err`=0, bus high-Z.
  - When `start`=1: latch `ri`, `num` and `sext`.
  - If `ri` ≥ NUM_REGS, set the err latch and go to DONE. The bus is never requested and no register is written.
  - Otherwise go to REQ.
- REQ: `bus_req`=1. Go to DRIVE when `bus_gnt`=1; otherwise stay. There is no timeout.
- DRIVE (exactly one cycle):
  - `bus_req`=1.
  - `out_to_bus` = extended immediate.
  - `r_write[ri_latched]`=1; all other bits 0.
  - Then go to DONE.
- DONE (exactly one cycle): `done`=1, `err` = latched flag, bus high-Z, `bus_req`=0. Then go to IDLE and clear the err latch.
- Extension rule:
  - Bits [IMM_W-1:0] = `num`.
  - Upper DATA_W-IMM_W bits = `num[IMM_W-1]` if the latched `sext`=1, else 0.
  - If IMM_W = DATA_W, the value is `num` unchanged.
- `start` outside IDLE is ignored; it is neither queued nor counted.
- Deasserting `bus_gnt` during DRIVE does not abort the write.
- Reset values: state IDLE, all latches 0, `bus_req`=0, `r_write`=0, `done`=0, `err`=0, `out_to_bus` high-Z.

## Timing
- `start` sampled at edge E0 → REQ during cycle 1.
- If `bus_gnt`=1 in cycle 1: DRIVE in cycle 2, `done` in cycle 3. Minimum latency is 3 cycles from the `start` edge to the `done` pulse.
- Each cycle of grant delay adds one cycle of latency.
- Error path: `start` at E0 with bad `ri` → `done`=1 and `err`=1 in cycle 1; no bus activity.
- Back-to-back: a new `start` is accepted in the cycle after DONE (IDLE). Peak throughput is 1 instruction per 4 cycles.
- Reset mid-operation (`reset`=1 at any edge): the next cycle is IDLE with all outputs at reset values. A partially issued write is dropped, and the bus is released within one cycle.
- `reset` has priority over `start` at the same edge.

## Configuration
- `MOVI_SEXT_EN` defined: the `sext` input is honoured as described in Operation.
- `MOVI_SEXT_EN` undefined:
  - `sext` is ignored and no sext latch is built.
  - The immediate is always zero-extended.
  - The port remains present for interface compatibility.

## Test plan
- Reset, then `start`, `ri`=2, `num`=6'h15, `sext`=0, `bus_gnt` tied 1:
  - Cycle 2: `out_to_bus`=16'h0015, `r_write`=4'b0100.
  - Cycle 3: `done`=1, `err`=0.
  - All other cycles: bus high-Z.
- `ri`=1, `num`=6'h2A, `sext`=1, with the macro defined:
  - DRIVE value is 16'hFFEA.
  - With the macro undefined, the same stimulus gives 16'h002A.
- `bus_gnt` held 0 for 5 cycles after REQ: `bus_req`=1 throughout, no `r_write`, bus high-Z. Grant in cycle 6 → DRIVE in cycle 7, `done` in cycle 8.
- `ri`=7 with NUM_REGS=4: `done`=1 and `err`=1 in cycle 1; `bus_req`, `r_write` and the bus remain idle.
- Extra `start` pulses in REQ/DRIVE/DONE, and `ri`/`num` changed after the issuing `start`: only the first instruction executes, using the latched operands.
- `reset` asserted in DRIVE: next cycle `r_write`=0, bus high-Z, no `done`. A `start` in the following cycle executes normally.
